life_scan_ctrl: RTL
===================

Name: life_scan_ctrl

Overview:
Scan-chain master for the 4x4 life tile.
- Serially loads a 16-cell pattern into the tile's scan chain (write), dumps the current generation out of it (read), or does both in one pass (exchange).
- Drives the tile's scan, scan_write_val and scan_write_enb inputs and samples its scan_read_val output.
- Gates the tile's run input so the array never evolves while the chain is shifting.

Parameters:
CELLS, 16, chain length (number of cells in the tile); the shift counter is clog2(CELLS)+1 bits wide.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_read  input  1  request a read pass; sampled in IDLE only
start_write  input  1  request a write pass; sampled in IDLE only; with start_read gives an exchange
wdata  input  CELLS  pattern to load, chain order; captured on the accepting edge
run_req  input  1  user request to let the tile evolve
scan_read_val  input  1  tail of the tile's chain (cell at chain position CELLS-1)
scan  output  1  shift enable to the tile
scan_write_val  output  1  serial data into the head of the chain
scan_write_enb  output  1  1 = inject scan_write_val; 0 = recirculate tail to head
run  output  1  run enable to the tile
rdata  output  CELLS  captured chain contents, chain order
busy  output  1  high while a pass is in progress
done  output  1  one-cycle pulse when a pass completes

Behaviour:
- Chain order: position p is the cell at row p/4, col p%4, i.e. alive bit index (p%4)*4 + p/4. Position 0 is the head and position 15 the tail for the default CELLS=16. wdata and rdata bit p correspond to chain position p.
- Reset: state=IDLE; scan=0, scan_write_enb=0, scan_write_val=0, busy=0, done=0, rdata=0, counter=0, run=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - run = run_req; scan=0.
  - If start_read|start_write: latch wdata into shift register wsr, latch the op bits (rd, wr), clear the counter, go to SHIFT.
  - Start inputs in any other state are ignored (no queuing).
- SHIFT:
  - scan=1, busy=1, run=0.
  - scan_write_enb = wr; scan_write_val = wsr[CELLS-1].
  - Each edge: wsr <= wsr<<1. If rd: rdata <= {rdata[CELLS-2:0], scan_read_val}. Counter increments.
  - After the edge that completes shift CELLS, go to DONE.
  - Exactly CELLS scan-high cycles per pass.
- DONE:
  - scan=0, busy=1, done=1 for exactly one cycle, run=0; then return to IDLE.
  - rdata holds until the next read or exchange completes its shifts. A write-only pass leaves rdata unchanged.
- Resulting state of the tile after a pass:
  - Read-only pass (wr=0): the chain recirculates, so after CELLS shifts the tile is restored bit-exact and rdata[p] = cell at position p.
  - Write pass: the first bit injected (wdata[CELLS-1]) ends at position CELLS-1, so after the pass the cell at position p = wdata[p].
  - Exchange: rdata receives the old pattern and the tile holds wdata.
- Latency: request accepted at edge k; scan high in cycles k+1..k+CELLS; done high in cycle k+CELLS+1; IDLE again from cycle k+CELLS+2. In IDLE, run follows run_req combinationally.
- run is forced to 0 from the accepting cycle's next cycle through DONE. A generation step never coincides with scan=1.
- Reset mid-pass: immediate return to IDLE, outputs as at reset, done is not pulsed. The tile is left partially rotated/loaded; the host must re-issue a write.
- Simultaneous start_read and start_write gives an exchange. A start held high after done simply launches the next pass from IDLE.

Test Plan:
- Write then read: write wdata=16'hA5C3, then read -> rdata=16'hA5C3. Tile alive bits match the mapping: position 0 -> alive[0], position 1 -> alive[4], position 5 -> alive[5], position 15 -> alive[15].
- Read non-destructive: load 16'h8001, read twice -> both rdata=16'h8001; tile unchanged after each pass; exactly 16 scan-high cycles per pass, done pulse 1 cycle at offset 17 from the accept edge.
- Exchange: tile=16'h00FF, start_read=start_write=1, wdata=16'h1234 -> rdata=16'h00FF, subsequent read gives 16'h1234.
- Run gating: run_req=1 throughout, issue a read -> run=0 from the cycle after accept through DONE, run=1 again in IDLE; a blinker pattern advances only while in IDLE.
- Start ignored while busy: pulse start_write with wdata=16'hFFFF at cycle 5 of a read pass -> no effect; tile retains the old pattern and a single done pulse occurs.
- Reset at shift 7 of a write -> scan=0, busy=0, done never pulses, rdata=0; a fresh write of 16'h0F0F then a read returns 16'h0F0F.

Source files
------------

// File: rtl/life_scan_ctrl.sv
// Scan-chain master for the 4x4 life tile: serial write, read or exchange of
// the tile pattern, with the tile's run input held off while the chain shifts.
module life_scan_ctrl #(
  parameter int CELLS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_read,
  input  logic             start_write,
  input  logic [CELLS-1:0] wdata,
  input  logic             run_req,
  input  logic             scan_read_val,
  output logic             scan,
  output logic             scan_write_val,
  output logic             scan_write_enb,
  output logic             run,
  output logic [CELLS-1:0] rdata,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(CELLS) + 1;
  localparam logic [CW-1:0] LAST = CW'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_wsr;
  logic [CELLS-1:0] r_rdata;
  logic [CW-1:0]    r_cnt;
  logic             r_rd;
  logic             r_wr;
  logic             r_scan;
  logic             r_swe;
  logic             r_busy;
  logic             r_done;

  // Pass sequencer: accept in IDLE, CELLS shift cycles, one DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wsr   <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_scan  <= 1'b0;
      r_swe   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start_read || start_write) begin
            r_wsr   <= wdata;
            r_rd    <= start_read;
            r_wr    <= start_write;
            r_cnt   <= '0;
            r_scan  <= 1'b1;
            r_swe   <= start_write;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_wsr <= r_wsr << 1;
          if (r_rd) begin
            r_rdata <= {r_rdata[CELLS-2:0], scan_read_val};
          end
          r_cnt <= r_cnt + CW'(1);
          // The edge that performs the last shift also leaves SHIFT.
          if (r_cnt == LAST) begin
            r_scan  <= 1'b0;
            r_swe   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_scan  <= 1'b0;
          r_swe   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign scan           = r_scan;
  assign scan_write_enb = r_swe;
  assign scan_write_val = r_wsr[CELLS-1];
  assign rdata          = r_rdata;
  assign busy           = r_busy;
  assign done           = r_done;
  // Only IDLE lets the tile evolve, so no generation step can meet a shift.
  assign run            = (r_state == IDLE) ? run_req : 1'b0;

endmodule
